// File: rtl/dctq_pkg.sv
// dctq_pkg: shared constants and types for the DCTQ dequantizer path.
//   COEF_W / QV_W / QS_W : output coefficient, quantized input and step widths
//   BLK_SIZE             : coefficients per 8x8 block
//   COEF_MAX / COEF_MIN  : saturation limits of the reconstructed coefficient
//   MAG_W                : width of the unsigned |q| * step product (plus rounding)
package dctq_pkg;

    localparam int COEF_W   = 12;
    localparam int QV_W     = 9;
    localparam int QS_W     = 8;
    localparam int BLK_SIZE = 64;
    localparam int IDX_W    = 6;
    localparam int COEF_MAX = 2047;
    localparam int COEF_MIN = -2048;
    // 256 * 255 + 127 = 65407 still fits in 17 bits, so rounding needs no extra bit.
    localparam int MAG_W    = QV_W + QS_W;

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [QV_W-1:0]   qv_t;
    typedef logic        [QS_W-1:0]   qs_t;
    typedef logic        [IDX_W-1:0]  idx_t;

endpackage

// File: rtl/dctq_qtable.sv
// dctq_qtable: 64-entry quantization step table.
//   clk   : clock
//   we    : write strobe; the entry changes at the next rising edge
//   waddr : write index, wdata : step written
//   raddr : read index, rdata : combinational read of the stored step
// Contents are deliberately not reset so a block reset keeps the loaded table.
// A read of the address being written in the same cycle returns the old value.
module dctq_qtable
    import dctq_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [QS_W-1:0]  wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [QS_W-1:0]  rdata
);

    logic [QS_W-1:0] mem_reg [BLK_SIZE];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/dctq_dequant.sv
// dctq_dequant: 3-stage stallable inverse quantizer.
//   clk, rst_n          : clock, asynchronous active-low reset
//   qt_we/addr/data     : quant-table write port (accepted regardless of stall)
//   in_valid/in_ready   : input handshake; in_q quantized coefficient,
//                         in_first marks coefficient 0 of a block
//   out_valid/out_ready : output handshake; out_coef reconstructed coefficient,
//                         out_last marks coefficient 63 of a block
//   blk_err             : one-cycle pulse after in_first arrives mid-block
// Build option: define DCTQ_DEQ_ROUND_EN to reconstruct nonzero coefficients at
// the bucket midpoint (|q|*step + step/2); otherwise |q|*step exactly.
module dctq_dequant
    import dctq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              qt_we,
    input  logic [IDX_W-1:0]  qt_addr,
    input  logic [QS_W-1:0]   qt_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [QV_W-1:0]   in_q,
    input  logic              in_first,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [COEF_W-1:0] out_coef,
    output logic              out_last,
    output logic              blk_err
);

    logic en;
    logic accept;
    idx_t idx_reg;
    idx_t idx_use;
    logic [QS_W-1:0] step_rd;
    logic [QV_W-1:0] in_mag;

    // Stage 1: sign / magnitude / step
    logic             s1_valid_reg;
    logic             s1_sign_reg;
    logic             s1_zero_reg;
    logic             s1_last_reg;
    logic [QV_W-1:0]  s1_mag_reg;
    logic [QS_W-1:0]  s1_step_reg;

    // Stage 2: unsigned product
    logic             s2_valid_reg;
    logic             s2_sign_reg;
    logic             s2_zero_reg;
    logic             s2_last_reg;
    logic [MAG_W-1:0] s2_mag_reg;
    logic [MAG_W-1:0] mag_next;

    // Stage 3: output register
    logic              out_valid_reg;
    logic              out_last_reg;
    logic [COEF_W-1:0] out_coef_reg;
    logic [COEF_W-1:0] sat_val;
    logic              blk_err_reg;

    // The whole pipeline moves as one: it advances whenever the output slot
    // is empty or being drained this cycle.
    assign en       = ~out_valid_reg | out_ready;
    assign in_ready = en;
    assign accept   = in_valid & en;

    // in_first forces the block to restart at index 0 even mid-block.
    assign idx_use = in_first ? '0 : idx_reg;

    // Two's complement magnitude; -256 maps to 9'h100 (256 unsigned).
    assign in_mag = in_q[QV_W-1] ? ((~in_q) + QV_W'(1)) : in_q;

    dctq_qtable u_qtable (
        .clk   (clk),
        .we    (qt_we),
        .waddr (qt_addr),
        .wdata (qt_data),
        .raddr (idx_use),
        .rdata (step_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg     <= '0;
            blk_err_reg <= 1'b0;
        end else begin
            blk_err_reg <= accept & in_first & (idx_reg != '0);
            if (accept) begin
                idx_reg <= idx_use + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_sign_reg  <= 1'b0;
            s1_zero_reg  <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_mag_reg   <= '0;
            s1_step_reg  <= '0;
        end else if (en) begin
            s1_valid_reg <= accept;
            s1_sign_reg  <= in_q[QV_W-1];
            s1_zero_reg  <= (in_q == '0);
            s1_last_reg  <= (idx_use == IDX_W'(BLK_SIZE - 1));
            s1_mag_reg   <= in_mag;
            s1_step_reg  <= step_rd;
        end
    end

`ifdef DCTQ_DEQ_ROUND_EN
    // Midpoint reconstruction undoes the bias of a truncating forward quantizer.
    assign mag_next = MAG_W'(s1_mag_reg) * MAG_W'(s1_step_reg) + MAG_W'(s1_step_reg >> 1);
`else
    assign mag_next = MAG_W'(s1_mag_reg) * MAG_W'(s1_step_reg);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_sign_reg  <= 1'b0;
            s2_zero_reg  <= 1'b0;
            s2_last_reg  <= 1'b0;
            s2_mag_reg   <= '0;
        end else if (en) begin
            s2_valid_reg <= s1_valid_reg;
            s2_sign_reg  <= s1_sign_reg;
            // A zero step would otherwise still pick up nothing, but with
            // rounding the zero-coefficient case must be forced explicitly.
            s2_zero_reg  <= s1_zero_reg | (s1_step_reg == '0);
            s2_last_reg  <= s1_last_reg;
            s2_mag_reg   <= mag_next;
        end
    end

    // Sign restore with saturation; negative side allows one extra step (2048).
    always_comb begin
        sat_val = '0;
        if (!s2_zero_reg) begin
            if (!s2_sign_reg) begin
                sat_val = (s2_mag_reg > MAG_W'(COEF_MAX)) ? COEF_W'(COEF_MAX)
                                                          : s2_mag_reg[COEF_W-1:0];
            end else begin
                sat_val = (s2_mag_reg > MAG_W'(-COEF_MIN)) ? COEF_W'(COEF_MIN)
                                                           : (COEF_W'(0) - s2_mag_reg[COEF_W-1:0]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_coef_reg  <= '0;
        end else if (en) begin
            out_valid_reg <= s2_valid_reg;
            // Gate with valid so a stale last flag in a bubble never surfaces.
            out_last_reg  <= s2_valid_reg & s2_last_reg;
            out_coef_reg  <= sat_val;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign out_coef  = out_coef_reg;
    assign blk_err   = blk_err_reg;

endmodule

// File: tb/tb_dctq_dequant.sv
// tb_dctq_dequant: scoreboard bench for dctq_dequant. The driver issues
// coefficients; the monitor (negedge) models table/index, pushes expected
// outputs on each accepted input and pops/compares on each accepted output.
module tb_dctq_dequant;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        qt_we;
    logic [5:0]  qt_addr;
    logic [7:0]  qt_data;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_q;
    logic        in_first;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_coef;
    logic        out_last;
    logic        blk_err;

    dctq_dequant dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .qt_we     (qt_we),
        .qt_addr   (qt_addr),
        .qt_data   (qt_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_q      (in_q),
        .in_first  (in_first),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_coef  (out_coef),
        .out_last  (out_last),
        .blk_err   (blk_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int coef;
        bit last;
    } exp_t;

    exp_t        sb[$];
    int          model_qt[64];
    int          model_idx;
    bit          exp_blk;
    bit          stall_prev;
    logic [11:0] prev_coef;
    logic        prev_last;
    int          stall_cnt;
    int          n_vec;
    int          n_err;
    int          ready_mode;   // 0 high, 1 low, 2 random

    // Behavioural reconstruction: value = sign(q) * (|q|*step [+ step/2]), clipped.
    function automatic int ref_coef(int q, int step);
        int mag;
        if (q == 0 || step == 0) return 0;
        mag = (q < 0 ? -q : q) * step;
`ifdef DCTQ_DEQ_ROUND_EN
        mag = mag + step / 2;
`endif
        if (q < 0) mag = -mag;
        if (mag > 2047) return 2047;
        if (mag < -2048) return -2048;
        return mag;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // out_ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor / model. Inputs only change just after posedge, so values seen
    // at negedge are the ones the next rising edge acts on.
    initial begin
        stall_prev = 1'b0;
        exp_blk    = 1'b0;
        model_idx  = 0;
        stall_cnt  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                model_idx  = 0;
                exp_blk    = 1'b0;
                stall_prev = 1'b0;
            end else begin
                bit new_blk;
                chk("blk_err", int'(blk_err), int'(exp_blk));
                if (stall_prev) begin
                    chk("hold_coef", int'($signed(out_coef)), int'($signed(prev_coef)));
                    chk("hold_last", int'(out_last), int'(prev_last));
                end
                if (out_valid && !out_ready) begin
                    stall_cnt++;
                    chk("in_ready_stall", int'(in_ready), 0);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_output: got coef %0d, expected none", int'($signed(out_coef)));
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("out_coef", int'($signed(out_coef)), e.coef);
                        chk("out_last", int'(out_last), int'(e.last));
                    end
                end
                new_blk = 1'b0;
                if (in_valid && in_ready) begin
                    int   use_idx;
                    exp_t e;
                    use_idx = in_first ? 0 : model_idx;
                    if (in_first && model_idx != 0) new_blk = 1'b1;
                    e.coef = ref_coef(int'($signed(in_q)), model_qt[use_idx]);
                    e.last = (use_idx == 63);
                    sb.push_back(e);
                    model_idx = (use_idx + 1) % 64;
                end
                // Table write applied after the read: same-cycle read sees old value.
                if (qt_we) model_qt[qt_addr] = int'(qt_data);
                exp_blk    = new_blk;
                stall_prev = out_valid && !out_ready;
                prev_coef  = out_coef;
                prev_last  = out_last;
            end
        end
    end

    task automatic send(int q, bit first);
        int guard;
        in_valid = 1'b1;
        in_q     = q[8:0];
        in_first = first;
        guard    = 0;
        @(negedge clk);
        while (!in_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) begin
            n_vec++;
            n_err++;
            $display("FAIL in_ready_timeout: got in_ready 0 for 1000 cycles, expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic wr_qt(int addr, int data);
        qt_we   = 1'b1;
        qt_addr = addr[5:0];
        qt_data = data[7:0];
        @(posedge clk);
        #1;
        qt_we = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d outputs pending, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        n_vec      = 0;
        n_err      = 0;
        ready_mode = 0;
        rst_n      = 1'b0;
        qt_we      = 1'b0;
        qt_addr    = '0;
        qt_data    = '0;
        in_valid   = 1'b0;
        in_q       = '0;
        in_first   = 1'b0;
        for (int i = 0; i < 64; i++) model_qt[i] = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_coef", int'(out_coef), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_blk_err", int'(blk_err), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);

        // All steps 16; first coefficient also measures pipeline latency:
        // accepting edge counted as 1, output must be valid after edge 3.
        for (int i = 0; i < 64; i++) wr_qt(i, 16);
        in_valid = 1'b1;
        in_q     = 9'd5;
        in_first = 1'b1;
        lat      = 0;
        while (lat < 10) begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 1) begin
                in_valid = 1'b0;
                in_first = 1'b0;
            end
            if (out_valid) break;
        end
        chk("latency", lat, 3);
        send(-3, 1'b0);
        drain();

        // Rounding examples at step 16
        send(5, 1'b1);
        send(-5, 1'b0);
        send(0, 1'b0);
        drain();

        // Saturation at step 255
        wr_qt(0, 255);
        send(255, 1'b1);
        send(-256, 1'b1);
        drain();

        // Full block with step = index+1, then one more wrapping to index 0
        for (int i = 0; i < 64; i++) wr_qt(i, i + 1);
        send(1, 1'b1);
        for (int i = 1; i < 65; i++) send(1, 1'b0);
        drain();

        // in_first at index 10 -> blk_err, uses qt[0], next uses qt[1]
        send(2, 1'b1);
        for (int i = 1; i < 10; i++) send(2, 1'b0);
        send(3, 1'b1);
        send(3, 1'b0);
        drain();

        // Stall for 5 cycles mid-stream
        stall_cnt = 0;
        fork
            for (int i = 0; i < 20; i++) send(i - 10, (i == 0));
            begin
                repeat (6) @(posedge clk);
                ready_mode = 1;
                repeat (5) @(posedge clk);
                ready_mode = 0;
            end
        join
        drain();
        chk("stall_cycles_seen", int'(stall_cnt >= 4), 1);

        // Same-cycle write and read of qt[0] returns the old value
        qt_we   = 1'b1;
        qt_addr = 6'd0;
        qt_data = 8'd200;
        send(7, 1'b1);
        qt_we = 1'b0;
        send(7, 1'b0);
        send(7, 1'b1);
        drain();

        // Randomized traffic with table writes and random backpressure
        ready_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            int q;
            bit first;
            if ($urandom_range(0, 7) == 0) begin
                qt_we   = 1'b1;
                qt_addr = 6'($urandom_range(0, 63));
                qt_data = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            end
            if ($urandom_range(0, 3) == 0) q = int'($urandom_range(0, 511)) - 256;
            else                           q = int'($urandom_range(0, 32)) - 16;
            first = ($urandom_range(0, 39) == 0);
            send(q, first);
            qt_we = 1'b0;
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        ready_mode = 0;
        drain();

        // Reset mid-block: pipeline discarded, index back to 0, table kept
        send(4, 1'b1);
        for (int i = 1; i < 20; i++) send(4, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send(3, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
